// File: rtl/sccb_init_seq.sv
// ---------------------------------------------------------------------------
// sccb_init_seq
//   Register-initialisation sequencer for the OV7725 camera. It walks a table
//   of {register address, value} entries held in an external synchronous ROM.
//   For each entry it issues one write request to the SCCB driver. It can
//   optionally read the register back and retry the write on a mismatch.
//   Entries whose address equals DELAY_ADDR are inline waits of
//   data*DELAY_UNIT cycles.
//
// Ports
//   clk_i          single clock
//   rst_i          synchronous active-high reset
//   start_i        start pulse, honoured in IDLE, DONE and FAIL only
//   busy_o         sequence in progress
//   init_done_o    sticky completion flag
//   error_o        sticky failure flag
//   err_index_o    table index of the entry that failed
//   rom_index_o    ROM address (the current table index)
//   rom_entry_i    {addr, data} from the ROM, one cycle after rom_index_o
//   sccb_addr_o    request register address
//   sccb_data_o    request write data
//   sccb_write_o   1 = write, 0 = read
//   sccb_valid_o   single-cycle request pulse
//   sccb_done_i    single-cycle completion pulse from the driver
//   sccb_rdata_i   read data, valid while sccb_done_i is high
//   dbg_state_o    current FSM state, for observation only
//
// Request handshake: sccb_valid_o is high for exactly one cycle per request.
// sccb_addr_o, sccb_data_o and sccb_write_o are stable from that cycle until
// the matching sccb_done_i. The driver answers each request with exactly one
// sccb_done_i pulse. A done pulse that arrives while no request is
// outstanding is ignored.
// ---------------------------------------------------------------------------
module sccb_init_seq #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    NUM_REGS       = 64,
  parameter int                    IDX_WIDTH      = 8,
  parameter logic [19:0]           POWERUP_CYCLES = 20'd1000000,
  parameter logic [ADDR_WIDTH-1:0] DELAY_ADDR     = {ADDR_WIDTH{1'b1}},
  parameter logic [15:0]           DELAY_UNIT     = 16'd1000,
  parameter int                    VERIFY         = 1,
  parameter int                    MAX_RETRY      = 3,
  parameter logic [19:0]           TIMEOUT_CYCLES = 20'd100000
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  output logic                             busy_o,
  output logic                             init_done_o,
  output logic                             error_o,
  output logic [IDX_WIDTH-1:0]             err_index_o,
  output logic [IDX_WIDTH-1:0]             rom_index_o,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] rom_entry_i,
  output logic [ADDR_WIDTH-1:0]            sccb_addr_o,
  output logic [DATA_WIDTH-1:0]            sccb_data_o,
  output logic                             sccb_write_o,
  output logic                             sccb_valid_o,
  input  logic                             sccb_done_i,
  input  logic [DATA_WIDTH-1:0]            sccb_rdata_i,
  output logic [3:0]                       dbg_state_o
);

  localparam int DLY_W = DATA_WIDTH + 16;
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PWR_WAIT, S_FETCH, S_DECODE, S_WR_REQ, S_WR_WAIT, S_RD_REQ,
    S_RD_WAIT, S_CHECK, S_DELAY, S_NEXT, S_DONE, S_FAIL
  } state_t;

  state_t                  state_q;
  logic [IDX_WIDTH-1:0]    idx_q;
  logic [RTY_W-1:0]        retry_q;
  logic [19:0]             pwr_cnt_q;
  logic [19:0]             to_cnt_q;
  logic [DLY_W-1:0]        dly_cnt_q;
  logic [DLY_W-1:0]        dly_tgt_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    busy_q;
  logic                    init_done_q;
  logic                    error_q;
  logic [IDX_WIDTH-1:0]    err_index_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    write_q;
  logic                    valid_q;

  logic [ADDR_WIDTH-1:0]   ent_addr;
  logic [DATA_WIDTH-1:0]   ent_data;
  logic [DLY_W-1:0]        dly_tgt_d;

  assign ent_addr  = rom_entry_i[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign ent_data  = rom_entry_i[DATA_WIDTH-1:0];
  // Full-width product so that a large delay value is never truncated.
  assign dly_tgt_d = DLY_W'(ent_data) * DLY_W'(DELAY_UNIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      pwr_cnt_q   <= '0;
      to_cnt_q    <= '0;
      dly_cnt_q   <= '0;
      dly_tgt_q   <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start_i) begin
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            idx_q       <= '0;
            retry_q     <= '0;
            pwr_cnt_q   <= '0;
            busy_q      <= 1'b1;
            // A zero power-up wait fetches entry 0 right after start.
            state_q     <= (POWERUP_CYCLES == 20'd0) ? S_FETCH : S_PWR_WAIT;
          end
        end
        S_PWR_WAIT: begin
          if (pwr_cnt_q + 20'd1 >= POWERUP_CYCLES) state_q <= S_FETCH;
          else pwr_cnt_q <= pwr_cnt_q + 20'd1;
        end
        // rom_index_o follows idx_q, so the ROM sees the address in this cycle.
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          addr_q <= ent_addr;
          data_q <= ent_data;
          if (ent_addr == DELAY_ADDR) begin
            dly_cnt_q <= '0;
            dly_tgt_q <= dly_tgt_d;
            state_q   <= (dly_tgt_d == '0) ? S_NEXT : S_DELAY;
          end else begin
            valid_q <= 1'b1;
            write_q <= 1'b1;
            state_q <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          valid_q  <= 1'b0;
          to_cnt_q <= '0;
          state_q  <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (sccb_done_i) begin
            if (VERIFY != 0) begin
              valid_q <= 1'b1;
              write_q <= 1'b0;
              state_q <= S_RD_REQ;
            end else begin
              state_q <= S_NEXT;
            end
          end else if (to_cnt_q + 20'd1 >= TIMEOUT_CYCLES) begin
            error_q     <= 1'b1;
            err_index_q <= idx_q;
            busy_q      <= 1'b0;
            state_q     <= S_FAIL;
          end else begin
            to_cnt_q <= to_cnt_q + 20'd1;
          end
        end
        S_RD_REQ: begin
          valid_q  <= 1'b0;
          to_cnt_q <= '0;
          state_q  <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (sccb_done_i) begin
            rdata_q <= sccb_rdata_i;
            state_q <= S_CHECK;
          end else if (to_cnt_q + 20'd1 >= TIMEOUT_CYCLES) begin
            error_q     <= 1'b1;
            err_index_q <= idx_q;
            busy_q      <= 1'b0;
            state_q     <= S_FAIL;
          end else begin
            to_cnt_q <= to_cnt_q + 20'd1;
          end
        end
        S_CHECK: begin
          if (rdata_q == data_q) begin
            state_q <= S_NEXT;
          end else if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_q <= retry_q + 1'b1;
            valid_q <= 1'b1;
            write_q <= 1'b1;
            state_q <= S_WR_REQ;
          end else begin
            error_q     <= 1'b1;
            err_index_q <= idx_q;
            busy_q      <= 1'b0;
            state_q     <= S_FAIL;
          end
        end
        S_DELAY: begin
          if (dly_cnt_q + DLY_W'(1) >= dly_tgt_q) state_q <= S_NEXT;
          else dly_cnt_q <= dly_cnt_q + DLY_W'(1);
        end
        S_NEXT: begin
          retry_q <= '0;
          if (idx_q == LAST_IDX) begin
            init_done_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign init_done_o  = init_done_q;
  assign error_o      = error_q;
  assign err_index_o  = err_index_q;
  assign rom_index_o  = idx_q;
  assign sccb_addr_o  = addr_q;
  assign sccb_data_o  = data_q;
  assign sccb_write_o = write_q;
  // Gated by reset so that a request pulse is withdrawn in the reset cycle
  // itself, not one cycle later.
  assign sccb_valid_o = valid_q & ~rst_i;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
module tb_sccb_init_seq;
  localparam int NR = 6;
  localparam int P  = 4;
  localparam int MR = 3;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, init_done, error;
  logic [7:0]  err_index, rom_index;
  logic [15:0] rom_entry;
  logic [7:0]  sccb_addr, sccb_data, sccb_rdata;
  logic        sccb_write, sccb_valid, sccb_done;
  logic [3:0]  dbg_state;

  sccb_init_seq #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REGS(NR), .IDX_WIDTH(8),
    .POWERUP_CYCLES(20'd4), .DELAY_ADDR(8'hFF), .DELAY_UNIT(16'd5),
    .VERIFY(1), .MAX_RETRY(MR), .TIMEOUT_CYCLES(20'd50)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy),
    .init_done_o(init_done), .error_o(error), .err_index_o(err_index),
    .rom_index_o(rom_index), .rom_entry_i(rom_entry), .sccb_addr_o(sccb_addr),
    .sccb_data_o(sccb_data), .sccb_write_o(sccb_write), .sccb_valid_o(sccb_valid),
    .sccb_done_i(sccb_done), .sccb_rdata_i(sccb_rdata), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- synchronous ROM model ----------------
  logic [15:0] rom [0:NR-1];
  always @(posedge clk) rom_entry <= (rom_index < NR) ? rom[rom_index] : 16'h0;

  // ---------------- SCCB driver model ----------------
  // drv_lat = 0 picks a random latency per request. drv_bad[a] counts how many
  // more reads of register a come back inverted.
  int         drv_lat = 1;
  bit         drv_hang = 0;
  int         drv_bad [256];
  logic [7:0] drv_regs [256];

  initial begin
    bit         pend;
    int         pcnt;
    bit         pw;
    logic [7:0] pa, pd;
    pend = 0; pcnt = 0; pw = 0; pa = 0; pd = 0;
    sccb_done = 0; sccb_rdata = 0;
    forever begin
      @(negedge clk);
      sccb_done = 0;
      if (rst) begin
        pend = 0;
      end else begin
        if (pend) begin
          pcnt--;
          if (pcnt == 0) begin
            pend = 0;
            chk("req_hold_cmd", {sccb_write, sccb_addr}, {pw, pa});
            if (pw) begin
              chk("req_hold_data", sccb_data, pd);
              drv_regs[pa] = pd;
            end else if (drv_bad[pa] > 0) begin
              drv_bad[pa]--;
              sccb_rdata = drv_regs[pa] ^ 8'hFF;
            end else begin
              sccb_rdata = drv_regs[pa];
            end
            sccb_done = 1;
          end
        end
        if (sccb_valid && !drv_hang) begin
          if (pend) chk("req_overlap", 1, 0);
          pend = 1; pw = sccb_write; pa = sccb_addr; pd = sccb_data;
          pcnt = (drv_lat > 0) ? drv_lat : $urandom_range(1, 6);
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q [$];   // {write, addr, data}
  bit          exp_done, exp_err;
  int          exp_eidx;

  // Expected request list from the table rules: one write per non-delay
  // entry, a read after each write, a re-write per mismatching read while
  // fewer than MR retries were used, else failure at that entry.
  task automatic build_expected(input bit hang);
    int mbad [256];
    int tries;
    logic [7:0] a, d;
    mbad = drv_bad;
    exp_q.delete();
    exp_done = 0; exp_err = 0; exp_eidx = 0;
    for (int i = 0; i < NR; i++) begin
      a = rom[i][15:8]; d = rom[i][7:0];
      if (a == 8'hFF) continue;
      exp_q.push_back({1'b1, a, d});
      if (hang) begin exp_err = 1; exp_eidx = i; return; end
      tries = 0;
      while (1) begin
        exp_q.push_back({1'b0, a, d});
        if (mbad[a] == 0) break;
        mbad[a]--;
        if (tries < MR) begin
          tries++;
          exp_q.push_back({1'b1, a, d});
        end else begin
          exp_err = 1; exp_eidx = i; return;
        end
      end
    end
    exp_done = 1;
  endtask

  // ---------------- monitor ----------------
  int first_valid_cyc = -1;
  int last_valid_cyc = -1;
  int err_rise_cyc = -1;
  int idx_cyc [0:7];

  initial begin
    bit prev_valid, prev_err;
    logic [7:0] prev_idx;
    logic [16:0] e;
    prev_valid = 0; prev_err = 0; prev_idx = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 0;
      end else begin
        if (sccb_valid) begin
          chk("valid_single_cycle", prev_valid, 0);
          last_valid_cyc = cyc;
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected_req", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("req_cmd", {sccb_write, sccb_addr}, e[16:8]);
            if (e[16]) chk("req_data", sccb_data, e[7:0]);
          end
        end
        prev_valid = sccb_valid;
      end
      if (rom_index != prev_idx) begin
        if (rom_index < 8) idx_cyc[rom_index] = cyc;
        prev_idx = rom_index;
      end
      if (error && !prev_err) err_rise_cyc = cyc;
      prev_err = error;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_bad();
    for (int i = 0; i < 256; i++) drv_bad[i] = 0;
  endtask

  task automatic rom_fixed();
    rom[0] = {8'h12, 8'h80}; rom[1] = {8'h0C, 8'h10}; rom[2] = {8'h11, 8'h01};
    rom[3] = {8'h17, 8'h22}; rom[4] = {8'h18, 8'hA4}; rom[5] = {8'h32, 8'h00};
  endtask

  task automatic pulse_start(output int ks);
    @(negedge clk); start = 1; ks = cyc;
    @(negedge clk); start = 0;
  endtask

  task automatic run_seq(input bit hang, input bit poke_start);
    int ks, n;
    build_expected(hang);
    first_valid_cyc = -1;
    for (int i = 0; i < 8; i++) idx_cyc[i] = -1;
    pulse_start(ks);
    chk("busy_after_start", busy, 1);
    chk("flags_cleared", {init_done, error}, 0);
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk); n++;
      start = (poke_start && (n == 15 || n == 40)) ? 1'b1 : 1'b0;
    end
    start = 0;
    if (n >= 5000) chk("busy_timeout", 1, 0);
    chk("init_done", init_done, exp_done);
    chk("error", error, exp_err);
    if (exp_err) chk("err_index", err_index, exp_eidx);
    chk("all_reqs_seen", exp_q.size(), 0);
    if (rom[0][15:8] != 8'hFF) chk("first_req_cycle", first_valid_cyc, ks + 3 + P);
    exp_q.delete();
  endtask

  task automatic rst_test(input int wait_after);
    int ks, n;
    drv_lat = 20;
    build_expected(0);
    pulse_start(ks);
    n = 0;
    while (!sccb_valid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("rst_test_no_req", 1, 0);
    repeat (wait_after) @(negedge clk);
    rst = 1;
    #1 chk("valid_drop_in_rst_cycle", sccb_valid, 0);
    @(negedge clk);
    chk("outputs_after_rst",
        {busy, init_done, error, err_index, rom_index, sccb_addr, sccb_data, sccb_write, sccb_valid}, 0);
    @(negedge clk); rst = 0;
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1; start = 0;
    clear_bad();
    for (int i = 0; i < 256; i++) drv_regs[i] = 8'h00;
    rom_fixed();
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {busy, init_done, error, err_index, rom_index, sccb_addr, sccb_data, sccb_write, sccb_valid}, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_after_reset", {busy, init_done, error}, 0);

    // Slow driver, clean table.
    drv_lat = 10; run_seq(0, 0);

    // Immediate driver: a verified entry takes 8 cycles.
    drv_lat = 1; run_seq(0, 0);
    chk("verified_entry_cycles", idx_cyc[2] - idx_cyc[1], 8);

    // Delay entries: 2*5 cycles, and a zero delay goes straight to NEXT.
    rom[1] = {8'hFF, 8'd2}; rom[3] = {8'hFF, 8'd0};
    run_seq(0, 0);
    chk("delay_entry_cycles", idx_cyc[2] - idx_cyc[1], 13);
    chk("zero_delay_cycles", idx_cyc[4] - idx_cyc[3], 3);
    rom_fixed();

    // Persistent mismatch (0x55 reads back as 0xAA): 1 write + 3 retries, fail.
    rom[2] = {8'h40, 8'h55}; drv_bad[8'h40] = 100;
    drv_lat = 0; run_seq(0, 0);
    chk("persistent_mismatch_index", err_index, 2);
    clear_bad(); rom_fixed();

    // One mismatch, then a match: the sequence still completes.
    drv_bad[8'h0C] = 1; run_seq(0, 0);
    clear_bad();

    // Driver never answers: timeout 50 cycles after the wait starts.
    drv_hang = 1; run_seq(1, 0);
    chk("timeout_cycle", err_rise_cyc, last_valid_cyc + 51);
    drv_hang = 0; drv_lat = 0; run_seq(0, 0);

    // Reset in the request cycle and in the wait state.
    rst_test(0);
    rst_test(3);
    drv_lat = 0; run_seq(0, 0);

    // start pulses while busy do not restart the sequence.
    run_seq(0, 1);

    // Randomised tables, mismatch counts and latencies.
    for (int r = 0; r < 20; r++) begin
      clear_bad();
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          rom[i] = {8'hFF, 8'($urandom_range(0, 3))};
        end else begin
          rom[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
          if ($urandom_range(0, 3) == 0) drv_bad[rom[i][15:8]] = $urandom_range(1, 4);
        end
      end
      drv_lat = 0;
      run_seq(0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
